// File: rtl/unicycle_sequencer.sv
// Sequencer for a single-ported unicycle CPU: fetches an instruction, lets the
// combinational ALU complex settle, performs at most one data read and one data write, then commits.
module unicycle_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] pc_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic [15:0] mem_data_q,
  input  logic        alu_mem_re,
  input  logic        alu_mem_we,
  input  logic [15:0] alu_mem_addr,
  input  logic [15:0] alu_mem_data,
  input  logic        alu_reg_we,
  input  logic        alu_pc_we,
  input  logic        alu_sp_we,
  input  logic        alu_ra_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        sp_we,
  output logic        ra_we,
  output logic        pc_inc,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETTLE = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    COMMIT = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT  = 8'(ACK_TIMEOUT);

  state_t      state;
  logic [3:0]  settle_cnt;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_next;
  logic        rd_done;
  logic [15:0] addr_q;

  assign wait_next = wait_cnt + 8'd1;

  // The PC register only updates on the COMMIT edge, so the fetch address must
  // follow pc_in live rather than be captured when FETCH is entered.
  assign mem_addr = (state == FETCH) ? pc_in : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      wait_cnt   <= 8'd0;
      rd_done    <= 1'b0;
      addr_q     <= 16'h0000;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= 16'h0000;
      instr      <= 16'h0000;
      mem_data_q <= 16'h0000;
      reg_we     <= 1'b0;
      pc_we      <= 1'b0;
      sp_we      <= 1'b0;
      ra_we      <= 1'b0;
      pc_inc     <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so each commit pulse lasts exactly one cycle.
      reg_we <= 1'b0;
      pc_we  <= 1'b0;
      sp_we  <= 1'b0;
      ra_we  <= 1'b0;
      pc_inc <= 1'b0;

      case (state)
        IDLE: begin
          if (run) begin
            state     <= FETCH;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_wdata <= 16'h0000;
            wait_cnt  <= 8'd0;
            busy      <= 1'b1;
          end
        end

        FETCH, MEM_RD, MEM_WR: begin
          if (!mem_ack) begin
            if (wait_next == WAIT_LIMIT) begin
              state   <= FAULT;
              fault   <= 1'b1;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              busy    <= 1'b0;
            end else begin
              wait_cnt <= wait_next;
            end
          end else begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == FETCH) begin
              instr      <= mem_rdata;
              rd_done    <= 1'b0;
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end else if (state == MEM_RD) begin
              mem_data_q <= mem_rdata;
              rd_done    <= 1'b1;
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end else begin
              state  <= COMMIT;
              reg_we <= alu_reg_we;
              pc_we  <= alu_pc_we;
              sp_we  <= alu_sp_we;
              ra_we  <= alu_ra_we;
              pc_inc <= !alu_pc_we;
            end
          end
        end

        SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else if (alu_mem_re && !rd_done) begin
            state    <= MEM_RD;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            addr_q   <= alu_mem_addr;
            wait_cnt <= 8'd0;
          end else if (alu_mem_we) begin
            state     <= MEM_WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            addr_q    <= alu_mem_addr;
            mem_wdata <= alu_mem_data;
            wait_cnt  <= 8'd0;
          end else begin
            state  <= COMMIT;
            reg_we <= alu_reg_we;
            pc_we  <= alu_pc_we;
            sp_we  <= alu_sp_we;
            ra_we  <= alu_ra_we;
            pc_inc <= !alu_pc_we;
          end
        end

        COMMIT: begin
          if (run) begin
            state     <= FETCH;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_wdata <= 16'h0000;
            wait_cnt  <= 8'd0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        FAULT: state <= FAULT;

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unicycle_sequencer.sv
// Directed bench for unicycle_sequencer: zero-wait memory model with a forced-ack
// hook, a small PC register model, and cycle-by-cycle expected values.
module tb_unicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] pc_q = 16'h0010;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] instr, mem_data_q;
  logic        alu_mem_re, alu_mem_we;
  logic [15:0] alu_mem_addr, alu_mem_data;
  logic        alu_reg_we, alu_pc_we, alu_sp_we, alu_ra_we;
  logic        reg_we, pc_we, sp_we, ra_we, pc_inc, busy, fault;

  logic        ack_en;
  logic        ack_force;
  logic [15:0] fetch_word;
  int          rd_cnt, wr_cnt;
  logic        strobe_seen;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign mem_ack   = (ack_en & mem_req) | ack_force;
  assign mem_rdata = (mem_addr == 16'h00F0) ? 16'h1234 : fetch_word;

  unicycle_sequencer #(.SETTLE_CYCLES(1), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_in(pc_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .mem_data_q(mem_data_q),
    .alu_mem_re(alu_mem_re), .alu_mem_we(alu_mem_we),
    .alu_mem_addr(alu_mem_addr), .alu_mem_data(alu_mem_data),
    .alu_reg_we(alu_reg_we), .alu_pc_we(alu_pc_we), .alu_sp_we(alu_sp_we), .alu_ra_we(alu_ra_we),
    .reg_we(reg_we), .pc_we(pc_we), .sp_we(sp_we), .ra_we(ra_we), .pc_inc(pc_inc),
    .busy(busy), .fault(fault)
  );

  // PC register model and data-access bookkeeping
  always @(posedge clk) begin
    if (pc_inc) pc_q <= pc_q + 16'd1;
    else if (pc_we) pc_q <= 16'h0100;
    if (mem_req && mem_ack && mem_addr == 16'h00F0) begin
      if (mem_we) wr_cnt <= wr_cnt + 1;
      else        rd_cnt <= rd_cnt + 1;
    end
    if (reg_we || pc_we || sp_we || ra_we || pc_inc) strobe_seen <= 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; ack_en = 1'b1; ack_force = 1'b0; fetch_word = 16'h0A05;
    alu_mem_re = 1'b0; alu_mem_we = 1'b0; alu_mem_addr = 16'h0000; alu_mem_data = 16'h0000;
    alu_reg_we = 1'b0; alu_pc_we = 1'b0; alu_sp_we = 1'b0; alu_ra_we = 1'b0;
    rd_cnt = 0; wr_cnt = 0; strobe_seen = 1'b0;
    step(2);

    // Reset state
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_mem_req", 16'(mem_req), 16'h0);
    check("rst_instr", instr, 16'h0000);
    check("rst_mem_data_q", mem_data_q, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_strobes", {11'd0, reg_we, pc_we, sp_we, ra_we, pc_inc}, 16'h0);
    check("rst_fault", 16'(fault), 16'h0);

    // ALU-only instruction: FETCH, SETTLE, COMMIT, then FETCH again on cycle 4
    rst = 1'b0; run = 1'b1;
    step(1);
    check("fetch_req", {15'd0, mem_req}, 16'h1);
    check("fetch_we", 16'(mem_we), 16'h0);
    check("fetch_addr", mem_addr, 16'h0010);
    check("fetch_busy", 16'(busy), 16'h1);
    step(1);
    check("instr_latched", instr, 16'h0A05);
    check("settle_req_low", 16'(mem_req), 16'h0);
    step(1);
    check("commit_pc_inc", 16'(pc_inc), 16'h1);
    check("commit_pc_we", 16'(pc_we), 16'h0);
    step(1);
    check("refetch_req", 16'(mem_req), 16'h1);
    check("refetch_addr", mem_addr, 16'h0011);
    check("refetch_pc_inc_low", 16'(pc_inc), 16'h0);

    // Read + write instruction with pc/reg writes
    alu_mem_re = 1'b1; alu_mem_we = 1'b1; alu_mem_addr = 16'h00F0; alu_mem_data = 16'hBEEF;
    alu_pc_we = 1'b1; alu_reg_we = 1'b1;
    step(1);
    check("rw_settle_req", 16'(mem_req), 16'h0);
    step(1);
    check("rd_req", 16'(mem_req), 16'h1);
    check("rd_we", 16'(mem_we), 16'h0);
    check("rd_addr", mem_addr, 16'h00F0);
    step(1);
    check("rd_data_q", mem_data_q, 16'h1234);
    check("rd_resettle_req", 16'(mem_req), 16'h0);
    step(1);
    check("wr_req", 16'(mem_req), 16'h1);
    check("wr_we", 16'(mem_we), 16'h1);
    check("wr_addr", mem_addr, 16'h00F0);
    check("wr_wdata", mem_wdata, 16'hBEEF);
    step(1);
    check("rw_commit_strobes", {11'd0, reg_we, pc_we, sp_we, ra_we, pc_inc}, 16'h0018);
    check("rw_commit_req", 16'(mem_req), 16'h0);
    step(1);
    check("rw_strobes_one_cycle", {11'd0, reg_we, pc_we, sp_we, ra_we, pc_inc}, 16'h0000);
    check("rw_pc_loaded_fetch", mem_addr, 16'h0100);
    check("data_reads", 16'(rd_cnt), 16'd1);
    check("data_writes", 16'(wr_cnt), 16'd1);

    // run dropped during FETCH: instruction still commits, then IDLE
    alu_mem_re = 1'b0; alu_mem_we = 1'b0; alu_pc_we = 1'b0; alu_reg_we = 1'b0;
    run = 1'b0;
    step(2);
    check("norun_commit_pc_inc", 16'(pc_inc), 16'h1);
    check("norun_commit_busy", 16'(busy), 16'h1);
    step(1);
    check("norun_idle_busy", 16'(busy), 16'h0);
    check("norun_idle_req", 16'(mem_req), 16'h0);
    step(1);
    check("norun_stays_idle", 16'(mem_req), 16'h0);

    // Reset during MEM_WR; ack arriving after release is ignored
    alu_mem_we = 1'b1; alu_mem_addr = 16'h0044; alu_mem_data = 16'h5555;
    run = 1'b1;
    step(2);
    ack_en = 1'b0;
    step(1);
    check("rstwr_in_write", {14'd0, mem_req, mem_we}, 16'h3);
    check("rstwr_addr", mem_addr, 16'h0044);
    rst = 1'b1; run = 1'b0;
    #1;
    check("rstwr_async_req", 16'(mem_req), 16'h0);
    check("rstwr_async_busy", 16'(busy), 16'h0);
    strobe_seen = 1'b0;
    step(1);
    rst = 1'b0; ack_force = 1'b1;
    step(1);
    ack_force = 1'b0;
    check("rstwr_ack_ignored_busy", 16'(busy), 16'h0);
    check("rstwr_ack_ignored_req", 16'(mem_req), 16'h0);
    step(1);
    check("rstwr_no_strobes", 16'(strobe_seen), 16'h0);
    check("rstwr_mem_wdata", mem_wdata, 16'h0000);

    // Timeout: memory never acks, ACK_TIMEOUT=4
    alu_mem_we = 1'b0; run = 1'b1;
    step(1);
    check("to_fetch_req", 16'(mem_req), 16'h1);
    step(3);
    check("to_still_waiting", {14'd0, fault, mem_req}, 16'h1);
    step(1);
    check("to_fault", 16'(fault), 16'h1);
    check("to_req_low", 16'(mem_req), 16'h0);
    check("to_busy_low", 16'(busy), 16'h0);
    ack_en = 1'b1;
    step(3);
    check("to_fault_sticky", {14'd0, fault, mem_req}, 16'h2);
    rst = 1'b1;
    #1;
    check("to_rst_clears", 16'(fault), 16'h0);
    step(1);
    rst = 1'b0; run = 1'b0;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
